ifetch_seq: RTL and testbench

Instruction-fetch sequencer that drives the PC register's write port and talks to instruction memory. It issues one fetch at a time at the current PC and advances the PC by 4 on each accepted request. Redirects from execute are applied immediately, and stale responses are discarded. Each fetched instruction and its PC are held in a one-entry buffer until decode accepts them.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_buf.sv | 29 ++
 rtl/ifetch_seq.sv | 118 +++++++++++
 tb/tb_ifetch_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry holding register for a fetched instruction and its PC.
module ifetch_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Clear wins over load; the sequencer never asserts both together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: one outstanding fetch, PC write-port control,
// redirect handling with stale-response drop, one-entry decode buffer.
module ifetch_seq #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            res,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_write,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  import ifetch_pkg::*;

  fetch_state_t    state, state_n;
  logic            drop, drop_n;
  logic [XLEN-1:0] req_pc, req_pc_n;
  logic            buf_load, buf_clear;
  logic            req_fire;

  assign imem_req_addr = pc_cur;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state  <= FETCH;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state  <= state_n;
      drop   <= drop_n;
      req_pc <= req_pc_n;
    end
  end

  // Next state plus the combinational handshake / PC-port outputs.
  // Everything is forced idle while reset is held.
  always_comb begin
    state_n        = state;
    drop_n         = drop;
    req_pc_n       = req_pc;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    pc_write       = 1'b0;
    pc_next        = '0;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    req_fire       = 1'b0;
    if (!res) begin
      case (state)
        FETCH: begin
          imem_req_valid = ~redirect_valid;
          req_fire       = ~redirect_valid & imem_req_ready;
          if (req_fire) begin
            req_pc_n = pc_cur;
            pc_write = 1'b1;
            pc_next  = pc_cur + XLEN'(INSTR_BYTES);
            state_n  = WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            // A response arriving with the redirect is the stale one itself.
            if (imem_rsp_valid) begin
              drop_n  = 1'b0;
              state_n = FETCH;
            end else begin
              drop_n = 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = FETCH;
            end else begin
              buf_load = 1'b1;
              state_n  = HOLD;
            end
          end
        end
        HOLD: begin
          if_valid = ~redirect_valid;
          if (redirect_valid || if_ready) begin
            buf_clear = 1'b1;
            state_n   = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
      if (redirect_valid) begin
        pc_write = 1'b1;
        pc_next  = {redirect_target[XLEN-1:2], 2'b00};
      end
    end
  end

  ifetch_buf #(.XLEN(XLEN)) u_buf (
    .clk      (clk),
    .rst      (res),
    .load     (buf_load),
    .clear    (buf_clear),
    .instr_in (imem_rsp_data),
    .pc_in    (req_pc),
    .instr    (if_instr),
    .pc       (if_pc)
  );

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ifetch_seq;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  ifetch_seq #(.XLEN(32), .INSTR_BYTES(4)) dut (
    .clk             (clk),
    .res             (res),
    .pc_cur          (pc),
    .pc_write        (pc_write),
    .pc_next         (pc_next),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Transaction-level model: a fetch in flight, whether it is stale, and
  // the instructions waiting for decode.
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_req_pc;
  logic [63:0] held[$];
  logic [31:0] pc_nxt;
  bit          fire;
  int unsigned mem_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance the model.
  task automatic apply(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic rdr, input logic [31:0] tg, input logic ifr);
    logic        e_rv, e_pw, e_iv;
    logic [31:0] e_pn;
    res = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
    redirect_valid = rdr; redirect_target = tg; if_ready = ifr;
    fire = 1'b0;
    if (r) begin
      e_rv = 1'b0; e_pw = 1'b0; e_pn = 32'd0; e_iv = 1'b0;
    end else begin
      e_rv = !m_out && held.size() == 0 && !rdr;
      e_iv = held.size() != 0 && !rdr;
      fire = e_rv && rdy;
      e_pw = rdr || fire;
      e_pn = rdr ? (tg & 32'hFFFF_FFFC) : (fire ? pc + 32'd4 : 32'd0);
    end
    @(negedge clk);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("req_addr", imem_req_addr, pc);
    chk("pc_write", 32'(pc_write), 32'(e_pw));
    if (e_pw || r) chk("pc_next", pc_next, e_pn);
    chk("if_valid", 32'(if_valid), 32'(e_iv));
    if (e_iv) begin
      chk("if_instr", if_instr, held[0][63:32]);
      chk("if_pc", if_pc, held[0][31:0]);
    end
    if (r) begin
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
    end
    if (r) begin
      m_out = 1'b0; m_stale = 1'b0; held.delete();
    end else if (rdr) begin
      if (m_out) begin
        if (rv) begin m_out = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
      held.delete();
    end else begin
      if (held.size() != 0 && ifr) void'(held.pop_front());
      if (m_out && rv) begin
        m_out = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else held.push_back({rd, m_req_pc});
      end
      if (fire) begin m_out = 1'b1; m_req_pc = pc; end
    end
    pc_nxt = e_pw ? e_pn : pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pc = pc_nxt;
  endtask

  initial begin
    pc = 32'd0; pc_nxt = 32'd0; m_out = 1'b0; m_stale = 1'b0; m_req_pc = 32'd0; mem_cnt = 0;
    res = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_target = 32'd0; if_ready = 1'b0;
    @(posedge clk); #1;

    // Reset, then a zero-wait fetch of 0x13 at PC 0.
    apply(1, 1, 0, 0, 0, 0, 1);
    chk("lit_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("lit_rst_if_valid", 32'(if_valid), 32'd0);
    tick();
    apply(0, 1, 0, 0, 0, 0, 1);
    chk("lit_req_addr0", imem_req_addr, 32'h0);
    chk("lit_pc_write0", 32'(pc_write), 32'd1);
    chk("lit_pc_next4", pc_next, 32'h4);
    tick();
    apply(0, 1, 1, 32'h13, 0, 0, 1);
    chk("lit_if_valid_n1", 32'(if_valid), 32'd0);
    tick();
    apply(0, 1, 0, 0, 0, 0, 1);
    chk("lit_if_valid_n2", 32'(if_valid), 32'd1);
    chk("lit_if_pc0", if_pc, 32'h0);
    chk("lit_if_instr13", if_instr, 32'h13);
    tick();

    // Memory stalls for three cycles before accepting.
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1);
      chk("lit_stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("lit_stall_pc_write", 32'(pc_write), 32'd0);
      tick();
    end
    apply(0, 1, 0, 0, 0, 0, 1);
    chk("lit_ready_pc_next", pc_next, 32'h8);
    tick();

    // Redirect while waiting: the later response is dropped.
    apply(0, 0, 0, 0, 1, 32'h103, 1);
    chk("lit_redir_pc_write", 32'(pc_write), 32'd1);
    chk("lit_redir_pc_next", pc_next, 32'h100);
    tick();
    apply(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 1);
    chk("lit_drop_if_valid", 32'(if_valid), 32'd0);
    tick();
    apply(0, 1, 0, 0, 0, 0, 1);
    chk("lit_refetch_addr", imem_req_addr, 32'h100);
    chk("lit_refetch_valid", 32'(imem_req_valid), 32'd1);
    tick();
    apply(0, 1, 1, 32'h55, 0, 0, 0);
    tick();

    // Decode stalls for four cycles: buffer held, no new request.
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0);
      chk("lit_hold_if_valid", 32'(if_valid), 32'd1);
      chk("lit_hold_if_pc", if_pc, 32'h100);
      chk("lit_hold_if_instr", if_instr, 32'h55);
      chk("lit_hold_no_req", 32'(imem_req_valid), 32'd0);
      tick();
    end

    // Redirect in HOLD coinciding with if_ready: no transfer.
    apply(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("lit_hold_redir_if_valid", 32'(if_valid), 32'd0);
    tick();
    apply(0, 1, 0, 0, 0, 0, 1);
    chk("lit_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("lit_wrap_pc_next", pc_next, 32'h0);
    tick();

    // Redirect together with the response: discarded, back to FETCH.
    apply(0, 0, 1, 32'h1234_5678, 1, 32'h200, 1);
    chk("lit_rsp_redir_pc_next", pc_next, 32'h200);
    tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("lit_after_rsp_redir_req", 32'(imem_req_valid), 32'd1);
    chk("lit_after_rsp_redir_ifv", 32'(if_valid), 32'd0);
    tick();

    // Reset mid-transaction; the late response must be ignored.
    apply(0, 1, 0, 0, 0, 0, 1);
    tick();
    apply(1, 0, 0, 0, 0, 0, 1);
    tick();
    apply(0, 0, 1, 32'hAAAA_AAAA, 0, 0, 1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("lit_post_rst_ifv", 32'(if_valid), 32'd0);
    chk("lit_post_rst_req", 32'(imem_req_valid), 32'd1);
    tick();

    // Redirect on the first cycle after reset.
    apply(1, 0, 0, 0, 0, 0, 1);
    tick();
    apply(0, 1, 0, 0, 1, 32'h45, 1);
    chk("lit_first_redir_pc_write", 32'(pc_write), 32'd1);
    chk("lit_first_redir_pc_next", pc_next, 32'h44);
    chk("lit_first_redir_req", 32'(imem_req_valid), 32'd0);
    tick();

    // Randomized traffic with variable-latency memory.
    for (int c = 0; c < 3000; c++) begin
      logic        r, rdy, rv, rdr, ifr;
      logic [31:0] rd, tg;
      r   = ($urandom_range(0, 199) == 0);
      rdr = ($urandom_range(0, 9) == 0);
      tg  = $urandom;
      ifr = ($urandom_range(0, 2) != 0);
      rdy = (mem_cnt == 0) && ($urandom_range(0, 3) != 0);
      rd  = $urandom;
      if (mem_cnt == 1) rv = 1'b1;
      else if (mem_cnt == 0 && !m_out) rv = ($urandom_range(0, 7) == 0);
      else rv = 1'b0;
      apply(r, rdy, rv, rd, rdr, tg, ifr);
      if (mem_cnt > 0) mem_cnt--;
      if (fire) mem_cnt = $urandom_range(1, 3);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
